// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address, checks width and alignment,
// drives one data-memory access with timeout, and returns formatted load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] ea;
  logic        legal, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign ea = req_base + req_imm;

  // Decode width, legality, alignment, byte enables and replicated store data
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    be_new     = 4'b0000;
    wdata_new  = 32'h0;
    case (req_funct3)
      3'b000: begin legal = 1'b1;       be_new = 4'b0001 << ea[1:0]; wdata_new = {4{req_wdata[7:0]}}; end
      3'b001: begin legal = 1'b1;       misaligned = ea[0];  be_new = 4'b0011 << ea[1:0]; wdata_new = {2{req_wdata[15:0]}}; end
      3'b010: begin legal = 1'b1;       misaligned = |ea[1:0]; be_new = 4'b1111; wdata_new = req_wdata; end
      3'b100: begin legal = !req_store; be_new = 4'b0001 << ea[1:0]; end
      3'b101: begin legal = !req_store; misaligned = ea[0];  be_new = 4'b0011 << ea[1:0]; end
      default: legal = 1'b0;
    endcase
    if (!req_store) wdata_new = 32'h0;
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    case (lane_q)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'h0, lane_byte};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!legal || misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            funct3_d    = req_funct3;
            lane_d      = ea[1:0];
            mem_we_d    = req_store;
            mem_addr_d  = {ea[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
          end
        end
      end
      ACCESS: begin
        if (mem_ack || cnt_q == CntLast) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = !mem_ack;
          resp_rdata_d = (mem_ack && !mem_we_q) ? load_data : 32'h0;
          cnt_d        = '0;
          mem_we_d     = 1'b0;
          mem_addr_d   = 32'h0;
          mem_be_d     = 4'b0000;
          mem_wdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    mem_req_d   = (state_d == ACCESS);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses, responses checked
// against a queue of expected results filled when each request is issued.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_base = 32'h0;
  logic [31:0] req_imm = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Reference formatting of a load result
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Response monitor: every resp_valid cycle must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      resp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h err=%b, required no response",
                 resp_rdata, resp_err);
      end else begin
        e = exp_q.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_fail++;
          $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                   resp_rdata, resp_err, e.rdata, e.err);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one request for one edge, then scramble the request fields
  task automatic send_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_base = base; req_imm = imm; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
    req_base = $urandom; req_imm = $urandom; req_wdata = $urandom;
  endtask

  task automatic test_reset();
    @(negedge clk); #1 rst_n = 1'b0; #1;
    n_checks++;
    if ({req_ready, mem_req, mem_we, mem_be, resp_valid, resp_err} !== 9'b1_0000000_0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b req=%b we=%b be=%b addr=%h wd=%h rv=%b rd=%h err=%b, required ready=1 rest 0",
               req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lb();
    exp_q.push_back('{rdata: 32'hFFFFFF80, err: 1'b0});
    send_req(1'b0, 3'b000, 32'h1000, 32'hFFFFFFFF, 32'h0);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h00000FFC || mem_be !== 4'b1000 ||
        mem_wdata !== 32'h0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_access: req=%b we=%b addr=%h be=%b wd=%h ready=%b, required 1 0 00000ffc 1000 0 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, req_ready);
    end
    mem_ack = 1'b1; mem_rdata = 32'h80FF0000;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_checks++;
    if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_latency: resp_valid=%b mem_req=%b, required 1 0", resp_valid, mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL lb_return_idle: ready=%b rv=%b rd=%h, required 1 0 ffffff80", req_ready, resp_valid, resp_rdata);
    end
  endtask

  task automatic test_sh_stall();
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    send_req(1'b1, 3'b001, 32'h2002, 32'h0, 32'h1234ABCD);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_be !== 4'b1100 ||
          mem_wdata !== 32'hABCDABCD) begin
        n_fail++;
        $display("FAIL sh_access[%0d]: req=%b we=%b addr=%h be=%b wd=%h, required 1 1 00002000 1100 abcdabcd",
                 i, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
      end
      if (i < 2) @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_latency: resp_valid=%b, required 1", resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b100};
    logic        sts [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] bas [3] = '{32'h3001, 32'h3000, 32'h3000};
    logic [31:0] ims [3] = '{32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
      send_req(sts[i], f3s[i], bas[i], ims[i], 32'h55AA55AA);
      n_checks++;
      if (mem_req !== 1'b0 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL err_req[%0d]: mem_req=%b resp_valid=%b ready=%b, required 0 1 0",
                 i, mem_req, resp_valid, req_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    send_req(1'b0, 3'b010, 32'h4000, 32'h0, 32'h0);
    for (int i = 0; i < int'(TO); i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait[%0d]: mem_req=%b addr=%h rv=%b, required 1 00004000 0",
                 i, mem_req, mem_addr, resp_valid);
      end
      @(negedge clk);
    end
    n_checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_expire: mem_req=%b resp_valid=%b, required 0 1", mem_req, resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_lhu_ack_at_timeout();
    exp_q.push_back('{rdata: 32'h0000F00D, err: 1'b0});
    send_req(1'b0, 3'b101, 32'h5000, 32'h2, 32'h0);
    n_checks++;
    if (mem_be !== 4'b1100 || mem_addr !== 32'h5000) begin
      n_fail++;
      $display("FAIL lhu_access: be=%b addr=%h, required 1100 00005000", mem_be, mem_addr);
    end
    repeat (int'(TO) - 1) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hF00D1234;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu_ack_edge: resp_valid=%b mem_req=%b, required 1 0", resp_valid, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_outside();
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle: ready=%b mem_req=%b rv=%b, required 1 0 0", req_ready, mem_req, resp_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    send_req(1'b1, 3'b010, 32'h6000, 32'h0, 32'hCAFEF00D);
    #2 rst_n = 1'b0; #1;
    n_checks++;
    if ({req_ready, mem_req, mem_we, mem_be, resp_valid, resp_err} !== 9'b1_0000000_0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_access: ready=%b req=%b we=%b be=%b addr=%h wd=%h rv=%b rd=%h err=%b, required ready=1 rest 0",
               req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL late_ack: rv=%b mem_req=%b ready=%b, required 0 0 1", resp_valid, mem_req, req_ready);
    end
    exp_q.push_back('{rdata: 32'h0000007F, err: 1'b0});
    send_req(1'b0, 3'b000, 32'h7000, 32'h1, 32'h0);
    n_checks++;
    if (mem_req !== 1'b1 || mem_be !== 4'b0010 || mem_addr !== 32'h7000) begin
      n_fail++;
      $display("FAIL post_reset_req: req=%b be=%b addr=%h, required 1 0010 00007000", mem_req, mem_be, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h00007F00;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  f3;
      logic        st;
      logic [31:0] base, imm, ea, wd, rd, x_wd;
      logic [3:0]  x_be;
      int          k;
      f3 = f3s[$urandom_range(4)];
      st = f3[2] ? 1'b0 : 1'($urandom_range(1));
      base = $urandom; imm = $urandom; wd = $urandom; rd = $urandom;
      ea = base + imm;
      if (f3[1:0] == 2'b01) begin imm = imm - {31'h0, ea[0]}; end
      if (f3[1:0] == 2'b10) begin imm = imm - {30'h0, ea[1:0]}; end
      ea = base + imm;
      case (f3[1:0])
        2'b00:   begin x_be = 4'b0001 << ea[1:0]; x_wd = {4{wd[7:0]}}; end
        2'b01:   begin x_be = 4'b0011 << ea[1:0]; x_wd = {2{wd[15:0]}}; end
        default: begin x_be = 4'b1111; x_wd = wd; end
      endcase
      if (!st) x_wd = 32'h0;
      exp_q.push_back('{rdata: st ? 32'h0 : model_load(f3, ea[1:0], rd), err: 1'b0});
      send_req(st, f3, base, imm, wd);
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== {ea[31:2], 2'b00} ||
          mem_be !== x_be || mem_wdata !== x_wd) begin
        n_fail++;
        $display("FAIL rand_access[%0d]: req=%b we=%b addr=%h be=%b wd=%h, required 1 %b %h %b %h",
                 i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, st, {ea[31:2], 2'b00}, x_be, x_wd);
      end
      k = $urandom_range(3);
      repeat (k) @(negedge clk);
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh_stall();
    test_errors();
    test_timeout();
    test_lhu_ack_at_timeout();
    test_ack_outside();
    test_reset_mid_access();
    test_random();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_resp: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
